// File: rtl/m92_video_pkg.sv
// m92_video_pkg: shared types and constants for the M92 video pixel path
//   pal_idx_t   - 11-bit palette index from the tile/sprite generators
//   rgb555_t    - packed 5:5:5 colour, blue in the top bits as stored in palette RAM
//   cpu_state_t - palette CPU bus access states
package m92_video_pkg;
   typedef logic [10:0] pal_idx_t;
   typedef struct packed {
      logic [4:0] b;
      logic [4:0] g;
      logic [4:0] r;
   } rgb555_t;
   typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} cpu_state_t;
   localparam logic [7:0] PAL_BANK_IO = 8'h02;
   localparam logic [3:0] OPQ_MASK    = 4'hF;
   // Pen 0 of every 16-colour group is transparent
   function automatic logic opaque(input pal_idx_t c);
      return |(c[3:0] & OPQ_MASK);
   endfunction
endpackage

// File: rtl/m92_palette_ram.sv
// m92_palette_ram: single-clock dual-port read-first BRAM
//   clk                          - clock
//   i_en_a, i_addr_a, o_q_a      - port A, read-only, registered read when enabled
//   i_we_b, i_addr_b, i_d_b, o_q_b - port B, read/write, registered read every clk
module m92_palette_ram #(
   parameter int AW = 12,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          i_en_a,
   input  logic [AW-1:0] i_addr_a,
   output logic [DW-1:0] o_q_a,
   input  logic          i_we_b,
   input  logic [AW-1:0] i_addr_b,
   input  logic [DW-1:0] i_d_b,
   output logic [DW-1:0] o_q_b
);
   logic [DW-1:0] r_mem [2**AW];
   // Both reads see the contents from before a same-clk port B write
   always_ff @(posedge clk) begin
      if (i_en_a) o_q_a <= r_mem[i_addr_a];
      if (i_we_b) r_mem[i_addr_b] <= i_d_b;
      o_q_b <= r_mem[i_addr_b];
   end
endmodule

// File: rtl/m92_pixel_mixer.sv
// m92_pixel_mixer: tile/sprite priority mix, palette lookup and 5:5:5 output
//   clk, reset                     - clock, synchronous active-high reset
//   ce_pix                         - pixel clock enable; the pixel pipe holds when low
//   tile_color, tile_prio          - tile palette index and tile-over-sprite priority
//   spr_color                      - sprite palette index
//   hblank_in..vsync_in            - timing from the tilemap generator
//   mem_cs, mem_rd, mem_wr, addr   - palette CPU bus (addr[11:1] = entry)
//   io_wr                          - I/O write strobe (addr[7:0] selects register)
//   cpu_din, cpu_dout, busy        - CPU data and wait request
//   red, green, blue               - pixel colour, LATENCY ce_pix ticks after input
//   hblank..vsync                  - timing delayed to match the colour
module m92_pixel_mixer #(
   parameter int PAL_AW  = 12,
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_pix,
   input  logic [10:0] tile_color,
   input  logic        tile_prio,
   input  logic [10:0] spr_color,
   input  logic        hblank_in,
   input  logic        vblank_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        mem_cs,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic        io_wr,
   input  logic [15:0] addr,
   input  logic [15:0] cpu_din,
   output logic [15:0] cpu_dout,
   output logic        busy,
   output logic [4:0]  red,
   output logic [4:0]  green,
   output logic [4:0]  blue,
   output logic        hblank,
   output logic        vblank,
   output logic        hsync,
   output logic        vsync
);
   import m92_video_pkg::*;
   logic              r_pal_bank;
   logic [PAL_AW-1:0] r_addr_a;
   logic [3:0]        r_tim [LATENCY-1];
   logic [15:0]       w_q_a;
   logic [15:0]       w_q_b;
   pal_idx_t          w_idx;
   rgb555_t           w_rgb;
   logic              w_blank;
   cpu_state_t        r_state;
   logic              r_armed;
   logic              r_we;
   logic [PAL_AW-2:0] r_cpu_addr;
   logic [15:0]       r_cpu_din;
   logic              w_req;
   logic              w_accept;
   logic              w_unused;

   assign w_unused = &{1'b0, addr[15:PAL_AW], addr[0], w_q_a[15]};

   // An opaque prioritised tile wins, then an opaque sprite; otherwise the
   // tile index is used so its pen 0 acts as the backdrop colour
   assign w_idx = (opaque(tile_color) & tile_prio) ? tile_color :
                  opaque(spr_color) ? spr_color : tile_color;

   always_ff @(posedge clk)
      if (reset) r_pal_bank <= 1'b0;
      else if (io_wr && addr[7:0] == PAL_BANK_IO) r_pal_bank <= cpu_din[0];

   // Stage 1: palette address; timing enters its delay line alongside
   always_ff @(posedge clk)
      if (reset) begin
         r_addr_a <= '0;
         for (int i = 0; i < LATENCY-1; i++) r_tim[i] <= '0;
      end else if (ce_pix) begin
         r_addr_a <= {r_pal_bank, w_idx};
         r_tim[0] <= {hblank_in, vblank_in, hsync_in, vsync_in};
         for (int i = 1; i < LATENCY-1; i++) r_tim[i] <= r_tim[i-1];
      end

   // Stage 3: blank uses the timing that leaves together with this colour
   assign w_blank = r_tim[LATENCY-2][3] | r_tim[LATENCY-2][2];
   assign w_rgb   = rgb555_t'(w_blank ? 15'd0 : w_q_a[14:0]);

   always_ff @(posedge clk)
      if (reset) begin
         {red, green, blue} <= '0;
         {hblank, vblank, hsync, vsync} <= '0;
      end else if (ce_pix) begin
         red   <= w_rgb.r;
         green <= w_rgb.g;
         blue  <= w_rgb.b;
         {hblank, vblank, hsync, vsync} <= r_tim[LATENCY-2];
      end

   // CPU access: strobe must drop for a clk before another access is accepted
   assign w_req    = mem_cs & (mem_rd | mem_wr);
   assign w_accept = (r_state == ST_IDLE) & w_req & r_armed;

   always_ff @(posedge clk)
      if (reset) begin
         r_state  <= ST_IDLE;
         busy     <= 1'b0;
         cpu_dout <= '0;
         r_armed  <= 1'b0;
      end else begin
         r_armed <= ~w_req | (r_armed & ~w_accept);
         case (r_state)
            ST_IDLE: if (w_accept) begin
               r_cpu_addr <= addr[PAL_AW-1:1];
               r_cpu_din  <= cpu_din;
               r_we       <= mem_wr;
               busy       <= 1'b1;
               r_state    <= ST_ACC;
            end
            ST_ACC: r_state <= ST_DONE;
            ST_DONE: begin
               if (!r_we) cpu_dout <= w_q_b;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end

   m92_palette_ram #(.AW(PAL_AW), .DW(16)) u_ram (
      .clk      (clk),
      .i_en_a   (ce_pix),
      .i_addr_a (r_addr_a),
      .o_q_a    (w_q_a),
      .i_we_b   ((r_state == ST_ACC) & r_we),
      .i_addr_b ({r_pal_bank, r_cpu_addr}),
      .i_d_b    (r_cpu_din),
      .o_q_b    (w_q_b)
   );
endmodule

// File: tb/tb_m92_pixel_mixer.sv
// tb_m92_pixel_mixer: directed and randomized checks of the pixel mixer against a palette model
module tb_m92_pixel_mixer;
   logic        clk = 1'b0;
   logic        reset, ce_pix, tile_prio;
   logic [10:0] tile_color, spr_color;
   logic        hblank_in, vblank_in, hsync_in, vsync_in;
   logic        mem_cs, mem_rd, mem_wr, io_wr;
   logic [15:0] addr, cpu_din, cpu_dout;
   logic        busy;
   logic [4:0]  red, green, blue;
   logic        hblank, vblank, hsync, vsync;
   int          total = 0;
   int          bad = 0;
   logic [15:0] pal [4096];
   int          bank_m = 0;

   always #5 clk = ~clk;

   m92_pixel_mixer dut (
      .clk(clk), .reset(reset), .ce_pix(ce_pix),
      .tile_color(tile_color), .tile_prio(tile_prio), .spr_color(spr_color),
      .hblank_in(hblank_in), .vblank_in(vblank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_wr(mem_wr), .io_wr(io_wr),
      .addr(addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
      .red(red), .green(green), .blue(blue),
      .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync)
   );

   // Reference: winner selection and colour decode from the palette model
   function automatic logic [14:0] exp_rgb(input logic [10:0] t, input logic p,
                                           input logic [10:0] s, input int b, input logic blank);
      logic [10:0] idx;
      int d;
      if (t % 16 != 0 && p) idx = t;
      else if (s % 16 != 0) idx = s;
      else idx = t;
      d = int'(pal[b * 2048 + int'(idx)]);
      if (blank) return 15'd0;
      return {5'(d % 32), 5'((d / 32) % 32), 5'((d / 1024) % 32)};
   endfunction

   // Called and returning at a falling edge
   task automatic cpu_access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                             output logic [15:0] q, output int n);
      mem_cs = 1'b1; mem_rd = !wr; mem_wr = wr; addr = a; cpu_din = d;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) n++;
         else if (n > 0) break;
      end
      q = cpu_dout;
      mem_cs = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      if (wr) pal[bank_m * 2048 + int'(a[11:1])] = d;
      @(negedge clk);
   endtask

   task automatic io_write(input logic [7:0] a, input logic [15:0] d);
      io_wr = 1'b1; addr = {8'h00, a}; cpu_din = d;
      @(negedge clk);
      io_wr = 1'b0;
      if (a == 8'h02) bank_m = int'(d[0]);
   endtask

   task automatic pix(input logic [10:0] t, input logic p, input logic [10:0] s,
                      input logic hb, input logic vb);
      ce_pix = 1'b1; tile_color = t; tile_prio = p; spr_color = s;
      hblank_in = hb; vblank_in = vb; hsync_in = 1'b0; vsync_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; ce_pix = 1'b1; hblank_in = 1'b1; vblank_in = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({red, green, blue, hblank, vblank, hsync, vsync, busy} !== 23'd0) begin
         bad++; $display("FAIL reset_outputs got=%h want=0", {red, green, blue, hblank, vblank, hsync, vsync, busy});
      end
      total++;
      if (cpu_dout !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", cpu_dout); end
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         total++;
         if (hblank !== (k == 3)) begin bad++; $display("FAIL reset_pipe_clear tick=%0d got=%b want=%b", k, hblank, k == 3); end
      end
      total++;
      if ({red, green, blue} !== 15'd0) begin bad++; $display("FAIL reset_blank_rgb got=%h want=0", {red, green, blue}); end
   endtask

   task automatic test_write_read();
      logic [15:0] q;
      int n;
      cpu_access(1'b1, 16'h0022, 16'h7C1F, q, n);
      total++;
      if (n !== 2) begin bad++; $display("FAIL busy_window_write got=%0d want=2", n); end
      repeat (3) pix(11'h011, 1'b0, 11'h000, 1'b0, 1'b0);
      total++;
      if ({red, green, blue} !== {5'd31, 5'd0, 5'd31}) begin
         bad++; $display("FAIL pixel_7c1f got=%0d/%0d/%0d want=31/0/31", red, green, blue);
      end
      cpu_access(1'b0, 16'h0022, 16'h0, q, n);
      total++;
      if (q !== 16'h7C1F) begin bad++; $display("FAIL read_7c1f got=%h want=7c1f", q); end
      total++;
      if (n !== 2) begin bad++; $display("FAIL busy_window_read got=%0d want=2", n); end
   endtask

   task automatic test_priority();
      logic [15:0] q;
      int n;
      cpu_access(1'b1, 16'h004A, 16'h001F, q, n);
      cpu_access(1'b1, 16'h0062, 16'h03E0, q, n);
      repeat (3) pix(11'h025, 1'b0, 11'h031, 1'b0, 1'b0);
      total++;
      if ({red, green, blue} !== {5'd0, 5'd31, 5'd0}) begin
         bad++; $display("FAIL sprite_over_tile got=%0d/%0d/%0d want=0/31/0", red, green, blue);
      end
      repeat (3) pix(11'h025, 1'b1, 11'h031, 1'b0, 1'b0);
      total++;
      if ({red, green, blue} !== {5'd31, 5'd0, 5'd0}) begin
         bad++; $display("FAIL tile_prio got=%0d/%0d/%0d want=31/0/0", red, green, blue);
      end
      repeat (3) pix(11'h030, 1'b1, 11'h031, 1'b0, 1'b0);
      total++;
      if ({red, green, blue} !== {5'd0, 5'd31, 5'd0}) begin
         bad++; $display("FAIL transparent_prio_tile got=%0d/%0d/%0d want=0/31/0", red, green, blue);
      end
   endtask

   task automatic test_transparent_blank();
      logic [15:0] q;
      int n;
      cpu_access(1'b1, 16'h0060, {1'b1, 5'd7, 5'd19, 5'd3}, q, n);
      repeat (3) pix(11'h030, 1'b1, 11'h040, 1'b0, 1'b0);
      total++;
      if ({red, green, blue} !== {5'd3, 5'd19, 5'd7}) begin
         bad++; $display("FAIL backdrop got=%0d/%0d/%0d want=3/19/7", red, green, blue);
      end
      for (int k = 1; k <= 3; k++) begin
         pix(11'h030, 1'b1, 11'h040, 1'b1, 1'b0);
         total++;
         if ({hblank, red, green, blue} !== ((k == 3) ? 16'h8000 : {1'b0, 5'd3, 5'd19, 5'd7})) begin
            bad++; $display("FAIL hblank_align tick=%0d got=%b/%h", k, hblank, {red, green, blue});
         end
      end
      ce_pix = 1'b0; tile_color = 11'h011; hblank_in = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if ({hblank, red, green, blue} !== 16'h8000) begin
         bad++; $display("FAIL freeze got=%b/%h want=1/0", hblank, {red, green, blue});
      end
      repeat (3) pix(11'h030, 1'b1, 11'h040, 1'b0, 1'b1);
      total++;
      if ({vblank, hblank, red, green, blue} !== 17'h10000) begin
         bad++; $display("FAIL vblank got=%b%b/%h want=10/0", vblank, hblank, {red, green, blue});
      end
   endtask

   task automatic test_bank();
      logic [15:0] q;
      int n;
      io_write(8'h02, 16'h0001);
      cpu_access(1'b1, 16'h0022, 16'h1234, q, n);
      cpu_access(1'b0, 16'h0022, 16'h0, q, n);
      total++;
      if (q !== 16'h1234) begin bad++; $display("FAIL bank1_read got=%h want=1234", q); end
      repeat (3) pix(11'h011, 1'b0, 11'h000, 1'b0, 1'b0);
      total++;
      if ({red, green, blue} !== {5'd20, 5'd17, 5'd4}) begin
         bad++; $display("FAIL bank1_pixel got=%0d/%0d/%0d want=20/17/4", red, green, blue);
      end
      io_write(8'h03, 16'h0000);
      cpu_access(1'b0, 16'h0022, 16'h0, q, n);
      total++;
      if (q !== 16'h1234) begin bad++; $display("FAIL other_io_ignored got=%h want=1234", q); end
      io_write(8'h02, 16'h0000);
      cpu_access(1'b0, 16'h0022, 16'h0, q, n);
      total++;
      if (q !== 16'h7C1F) begin bad++; $display("FAIL bank0_intact got=%h want=7c1f", q); end
   endtask

   task automatic test_collision();
      repeat (3) pix(11'h011, 1'b0, 11'h000, 1'b0, 1'b0);
      mem_cs = 1'b1; mem_wr = 1'b1; addr = 16'h0022; cpu_din = 16'h03E0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 3) begin mem_cs = 1'b0; mem_wr = 1'b0; end
         total++;
         if ({red, green, blue} !== ((k == 4) ? {5'd0, 5'd31, 5'd0} : {5'd31, 5'd0, 5'd31})) begin
            bad++; $display("FAIL collision tick=%0d got=%0d/%0d/%0d", k, red, green, blue);
         end
      end
      pal[11'h011] = 16'h03E0;
   endtask

   task automatic test_reset_acc();
      logic [15:0] q;
      int n;
      mem_cs = 1'b1; mem_wr = 1'b1; addr = 16'h0024; cpu_din = 16'hABCD;
      @(negedge clk);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL acc_busy got=%b want=1", busy); end
      reset = 1'b1; mem_cs = 1'b0; mem_wr = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_in_acc got=%b want=0", busy); end
      reset = 1'b0; bank_m = 0; pal[11'h012] = 16'hABCD;
      @(negedge clk);
      cpu_access(1'b0, 16'h0024, 16'h0, q, n);
      total++;
      if (q !== 16'hABCD) begin bad++; $display("FAIL acc_write_kept got=%h want=abcd", q); end
   endtask

   task automatic test_random();
      logic [15:0] q;
      int n;
      logic [18:0] exp_q[$];
      logic [18:0] cur;
      logic have;
      logic c, p, hb, vb, hs, vs, iow, nb;
      logic [10:0] t, s;
      for (int b = 0; b < 2; b++) begin
         io_write(8'h02, 16'(b));
         for (int i = 0; i < 64; i++) cpu_access(1'b1, 16'(i * 2), 16'($urandom), q, n);
      end
      io_write(8'h02, 16'h0000);
      have = 1'b0; cur = '0;
      for (int k = 0; k < 500; k++) begin
         c = ($urandom % 4) != 0; p = 1'($urandom); t = 11'($urandom % 64); s = 11'($urandom % 64);
         hb = ($urandom % 8) == 0; vb = ($urandom % 16) == 0; hs = 1'($urandom); vs = 1'($urandom);
         iow = ($urandom % 16) == 0; nb = 1'($urandom);
         ce_pix = c; tile_color = t; tile_prio = p; spr_color = s;
         hblank_in = hb; vblank_in = vb; hsync_in = hs; vsync_in = vs;
         io_wr = iow; addr = 16'h0002; cpu_din = {15'h0, nb};
         if (c) exp_q.push_back({hb, vb, hs, vs, exp_rgb(t, p, s, bank_m, hb | vb)});
         @(negedge clk);
         if (iow) bank_m = int'(nb);
         if (c && exp_q.size() == 3) begin cur = exp_q.pop_front(); have = 1'b1; end
         if (have) begin
            total++;
            if ({hblank, vblank, hsync, vsync, red, green, blue} !== cur) begin
               bad++; $display("FAIL random k=%0d got=%h want=%h", k, {hblank, vblank, hsync, vsync, red, green, blue}, cur);
            end
         end
      end
      io_wr = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ce_pix = 1'b0; tile_color = '0; tile_prio = 1'b0; spr_color = '0;
      hblank_in = 1'b0; vblank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
      mem_cs = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; io_wr = 1'b0; addr = '0; cpu_din = '0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_priority();
      test_transparent_blank();
      test_bank();
      test_collision();
      test_reset_acc();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end
endmodule
